// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: widths, FSM encoding, port ids.
package dm_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_DBG = 2'd2
  } state_e;

  // Port ids double as bit positions in the grant vector.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select between CPU and debug requesters.
// DM_ARB_RR_EN selects round-robin; otherwise the CPU has fixed priority.
module dm_arb_pick
  import dm_pkg::*;
(
`ifdef DM_ARB_RR_EN
  input  logic       last_winner,
`endif
  input  logic       cpu_req,
  input  logic       dbg_req,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
`ifdef DM_ARB_RR_EN
    // On contention the port that did not win last time goes first.
    if (cpu_req && dbg_req) begin
      if (last_winner == PORT_CPU) gnt_c[PORT_DBG] = 1'b1;
      else                         gnt_c[PORT_CPU] = 1'b1;
    end else if (cpu_req) begin
      gnt_c[PORT_CPU] = 1'b1;
    end else if (dbg_req) begin
      gnt_c[PORT_DBG] = 1'b1;
    end
`else
    if (cpu_req)      gnt_c[PORT_CPU] = 1'b1;
    else if (dbg_req) gnt_c[PORT_DBG] = 1'b1;
`endif
  end

endmodule

// File: rtl/dm_arb.sv
// Two-port arbiter/sequencer for the data memory: one access per accepted command,
// registered ack two edges after grant. DM_ARB_RR_EN enables round-robin arbitration.
module dm_arb
  import dm_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  output logic          dm_re,
  input  logic [DW-1:0] dm_dout
);

  state_e        state_q, state_d;
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    pick_gnt;
  logic          acc;
`ifdef DM_ARB_RR_EN
  logic          last_winner_q, last_winner_d;
`endif

  dm_arb_pick u_pick (
`ifdef DM_ARB_RR_EN
    .last_winner (last_winner_q),
`endif
    .cpu_req     (cpu_req),
    .dbg_req     (dbg_req),
    .gnt_c       (pick_gnt)
  );

  assign cpu_gnt   = pick_gnt[PORT_CPU] & ~rst;
  assign dbg_gnt   = pick_gnt[PORT_DBG] & ~rst;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign rdata     = rdata_q;
  assign acc       = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: every edge goes straight to the winner's access, or idle
  always_comb begin
    state_d = IDLE;
    if (cpu_gnt)      state_d = ACC_CPU;
    else if (dbg_gnt) state_d = ACC_DBG;
  end

  // Command, ack and read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      rdata_q     <= '0;
`ifdef DM_ARB_RR_EN
      last_winner_q <= PORT_DBG;
`endif
    end else begin
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      rdata_q     <= rdata_d;
`ifdef DM_ARB_RR_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  always_comb begin
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (cpu_gnt) begin
      cmd_we_d    = cpu_we;
      cmd_addr_d  = cpu_addr;
      cmd_wdata_d = cpu_wdata;
    end else if (dbg_gnt) begin
      cmd_we_d    = dbg_we;
      cmd_addr_d  = dbg_addr;
      cmd_wdata_d = dbg_wdata;
    end
    cpu_ack_d = (state_q == ACC_CPU);
    dbg_ack_d = (state_q == ACC_DBG);
    rdata_d   = rdata_q;
    if (acc && !cmd_we_q) rdata_d = dm_dout;
`ifdef DM_ARB_RR_EN
    last_winner_d = last_winner_q;
    if (cpu_gnt)      last_winner_d = PORT_CPU;
    else if (dbg_gnt) last_winner_d = PORT_DBG;
`endif
  end

  // Memory-side outputs; reset squashes any access in flight
  always_comb begin
    dm_addr = cmd_addr_q;
    dm_din  = cmd_wdata_q;
    dm_we   = acc & cmd_we_q & ~rst;
    dm_re   = acc & ~cmd_we_q & ~rst;
  end

endmodule

// File: tb/tb_dm_arb.sv
// Self-checking bench for dm_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter and memory.
module tb_dm_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_ack, dbg_gnt, dbg_ack;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [4:0]  dm_addr;
  logic        dm_we, dm_re;

  logic [31:0] tb_mem [32];

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, last winner, one command in flight
  logic [31:0] mdl_mem [32];
  logic        lw;
  logic        s1_v, s1_port, s1_we;
  logic [4:0]  s1_addr;
  logic [31:0] s1_wdata;
  logic        exp_cpu_ack, exp_dbg_ack;
  logic [31:0] exp_rdata;
  int          last_w;

  dm_arb dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack),
    .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_re(dm_re),
    .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = tb_mem[dm_addr];
  always @(posedge clk) if (dm_we) tb_mem[dm_addr] <= dm_din;

  // 0 = nobody, 1 = CPU, 2 = DBG
  function automatic int pred_win();
    if (rst) return 0;
`ifdef DM_ARB_RR_EN
    if (cpu_req && dbg_req) return lw ? 1 : 2;
`endif
    if (cpu_req) return 1;
    if (dbg_req) return 2;
    return 0;
  endfunction

  // Advance one clock; the model retires the in-flight access, then accepts the winner
  task automatic tick();
    int w;
    w = pred_win();
    exp_cpu_ack = 1'b0;
    exp_dbg_ack = 1'b0;
    if (!rst && s1_v) begin
      if (s1_we) mdl_mem[s1_addr] = s1_wdata;
      else       exp_rdata = mdl_mem[s1_addr];
      exp_cpu_ack = (s1_port == 1'b0);
      exp_dbg_ack = (s1_port == 1'b1);
    end
    if (rst) begin
      exp_rdata = 32'h0;
      lw = 1'b1;
    end
    s1_v = (w != 0);
    if (w == 1) begin
      s1_port = 1'b0; s1_we = cpu_we; s1_addr = cpu_addr; s1_wdata = cpu_wdata; lw = 1'b0;
    end else if (w == 2) begin
      s1_port = 1'b1; s1_we = dbg_we; s1_addr = dbg_addr; s1_wdata = dbg_wdata; lw = 1'b1;
    end
    last_w = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd2; dbg_wdata = 32'h5;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
        errors++; $display("FAIL rst_gnt got %b%b want 00", cpu_gnt, dbg_gnt);
      end
      tick();
      checks++;
      if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0 || dm_we !== 1'b0 || dm_re !== 1'b0) begin
        errors++; $display("FAIL rst_strobe got ack %b%b we %b re %b want 0", cpu_ack, dbg_ack, dm_we, dm_re);
      end
      checks++;
      if (rdata !== 32'h0 || dm_addr !== 5'd0 || dm_din !== 32'h0) begin
        errors++; $display("FAIL rst_vals got rdata %h addr %h din %h want 0", rdata, dm_addr, dm_din);
      end
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL wr_gnt got gnt %b stall %b want 1 0", cpu_gnt, cpu_stall);
    end
    tick();
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    #1;
    checks++;
    if (dm_we !== 1'b1 || dm_addr !== 5'd3 || dm_din !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_access got we %b addr %h din %h want 1 03 deadbeef", dm_we, dm_addr, dm_din);
    end
    tick();
    cpu_req = 1'b0;
    checks++;
    if (dm_we !== 1'b0 || dm_re !== 1'b1 || cpu_ack !== 1'b1) begin
      errors++; $display("FAIL rd_access got we %b re %b ack %b want 0 1 1", dm_we, dm_re, cpu_ack);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_rd_data got ack %b rdata %h want 1 deadbeef", cpu_ack, rdata);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL ack_pulse got %b want 0", cpu_ack);
    end
    idle(1);
  endtask

  task automatic test_both_reads();
    int prev;
    prev = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
`ifdef DM_ARB_RR_EN
      if ((cpu_gnt ^ dbg_gnt) !== 1'b1 || (prev == 1 && cpu_gnt) || (prev == 2 && dbg_gnt)) begin
        errors++; $display("FAIL rr_alt got gnt %b%b prev %0d", cpu_gnt, dbg_gnt, prev);
      end
`else
      if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
        errors++; $display("FAIL fix_pri got gnt %b%b stall %b want 10 0", cpu_gnt, dbg_gnt, cpu_stall);
      end
`endif
      tick();
      prev = last_w;
      checks++;
      if (cpu_ack !== exp_cpu_ack || dbg_ack !== exp_dbg_ack ||
          ((cpu_ack || dbg_ack) && rdata !== exp_rdata)) begin
        errors++; $display("FAIL both_ack got %b%b %h want %b%b %h", cpu_ack, dbg_ack, rdata,
                           exp_cpu_ack, exp_dbg_ack, exp_rdata);
      end
    end
    idle(2);
  endtask

  task automatic test_dbg_write_cpu_read();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd31; dbg_wdata = 32'h12345678;
    #1;
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++; $display("FAIL dbg_gnt got %b%b want 01", cpu_gnt, dbg_gnt);
    end
    tick();
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd31;
    #1;
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL cpu31_gnt got gnt %b stall %b want 1 0", cpu_gnt, cpu_stall);
    end
    tick();
    cpu_req = 1'b0;
    checks++;
    if (dbg_ack !== 1'b1 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL dbg_ack got %b%b want 01", cpu_ack, dbg_ack);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || rdata !== 32'h12345678) begin
      errors++; $display("FAIL cpu31_data got ack %b rdata %h want 1 12345678", cpu_ack, rdata);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd7; cpu_wdata = 32'hAAAA5555;
    tick();
    cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (dm_we !== 1'b0) begin
      errors++; $display("FAIL mid_rst_we got %b want 0", dm_we);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ack got %b want 0", cpu_ack);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ack2 got %b want 0", cpu_ack);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
    tick();
    cpu_req = 1'b0;
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL mid_rst_rd got ack %b rdata %h want 1 0", cpu_ack, rdata);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'(t); cpu_wdata = 32'hC0DE0000 + 32'(t);
        #1;
        checks++;
        if (cpu_gnt !== 1'b1) begin
          errors++; $display("FAIL b2b_gnt t=%0d got %b want 1", t, cpu_gnt);
        end
      end else begin
        cpu_req = 1'b0;
      end
      tick();
      checks++;
      if (cpu_ack !== ((t >= 1 && t <= 8) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL b2b_ack t=%0d got %b", t, cpu_ack);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tb_mem[i] !== 32'hC0DE0000 + 32'(i)) begin
        errors++; $display("FAIL b2b_mem[%0d] got %h want %h", i, tb_mem[i], 32'hC0DE0000 + 32'(i));
      end
    end
  endtask

  task automatic test_random();
    logic cpu_pend, dbg_pend;
    int   w;
    cpu_pend = 1'b0;
    dbg_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!cpu_pend && ($urandom % 3) != 0) begin
        cpu_pend = 1'b1; cpu_we = 1'($urandom); cpu_addr = 5'($urandom % 8); cpu_wdata = $urandom;
      end
      if (!dbg_pend && ($urandom % 3) != 0) begin
        dbg_pend = 1'b1; dbg_we = 1'($urandom); dbg_addr = 5'($urandom % 8); dbg_wdata = $urandom;
      end
      cpu_req = cpu_pend;
      dbg_req = dbg_pend;
      rst = (($urandom % 40) == 0);
      #1;
      w = pred_win();
      checks++;
      if (cpu_gnt !== (w == 1) || dbg_gnt !== (w == 2) || cpu_stall !== (cpu_req && w != 1)) begin
        errors++; $display("FAIL rnd_gnt c=%0d got %b%b stall %b want win %0d", c, cpu_gnt, dbg_gnt, cpu_stall, w);
      end
      tick();
      rst = 1'b0;
      if (last_w == 1) cpu_pend = 1'b0;
      if (last_w == 2) dbg_pend = 1'b0;
      checks++;
      if (cpu_ack !== exp_cpu_ack || dbg_ack !== exp_dbg_ack ||
          ((cpu_ack || dbg_ack) && rdata !== exp_rdata)) begin
        errors++; $display("FAIL rnd_ack c=%0d got %b%b %h want %b%b %h", c, cpu_ack, dbg_ack, rdata,
                           exp_cpu_ack, exp_dbg_ack, exp_rdata);
      end
    end
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = 32'h0;
      mdl_mem[i] = 32'h0;
    end
    lw = 1'b1; s1_v = 1'b0; s1_port = 1'b0; s1_we = 1'b0; s1_addr = 5'd0; s1_wdata = 32'h0;
    exp_cpu_ack = 1'b0; exp_dbg_ack = 1'b0; exp_rdata = 32'h0; last_w = 0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_both_reads();
    test_dbg_write_cpu_read();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
